// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC requests to instruction memory,
// in-order responses buffered with their PC in a small queue feeding decode.
module fetch_queue_unit #(
  parameter int unsigned        XLEN            = 64,
  parameter logic [XLEN-1:0]    RESET_PC        = '0,
  parameter int unsigned        QDEPTH          = 4,
  parameter int unsigned        MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_idle
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + IW;

  logic            r_run;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   r_drop_cnt;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [31:0]     r_q_instr [QDEPTH];
  logic [XLEN-1:0] r_q_pc    [QDEPTH];

  logic [SW-1:0]   w_used;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_ok;
  logic            w_rsp_drop;
  logic            w_push;
  logic            w_id_valid;
  logic            w_pop;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused_redir;

  // Credit: slots already owed to live (non-dropped) responses count as used.
  assign w_used      = SW'(r_count) + SW'(r_inflight) - SW'(r_drop_cnt);
  assign w_req_valid = r_run && !redirect_valid && (r_inflight < IW'(MAX_OUTSTANDING))
                       && (w_used < SW'(QDEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_rsp_ok    = imem_rsp_valid && (r_inflight != '0);
  assign w_rsp_drop  = w_rsp_ok && (r_drop_cnt != '0);
  assign w_push      = w_rsp_ok && (r_drop_cnt == '0) && !redirect_valid;
  assign w_id_valid  = (r_count != '0) && !redirect_valid;
  assign w_pop       = w_id_valid && id_ready;
  assign w_redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redir = ^redirect_pc[1:0];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign id_valid       = w_id_valid;
  assign id_instr       = r_q_instr[r_head];
  assign id_pc          = r_q_pc[r_head];
  assign fetch_idle     = (r_count == '0) && (r_inflight == '0);

  // Fetch/response PCs, occupancy, in-flight and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= r_inflight + IW'(w_req_fire) - IW'(w_rsp_ok);
      if (redirect_valid) begin
        // Every response still owed after this cycle belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_drop_cnt <= r_inflight - IW'(w_rsp_ok);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_tail   <= r_tail + PW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        if (w_rsp_drop) begin
          r_drop_cnt <= r_drop_cnt - IW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage: word and PC written at the tail on an accepted response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_instr[i] <= 32'h0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_tail] <= imem_rsp_data;
      r_q_pc[r_tail]    <= r_rsp_pc;
    end else begin
      r_q_instr[r_tail] <= r_q_instr[r_tail];
    end
  end

  fetch_queue_unit_chk #(.IW(IW)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .rsp_valid (imem_rsp_valid),
    .inflight  (r_inflight)
  );

endmodule

// Protocol checker: a response with nothing in flight is illegal.
module fetch_queue_unit_chk #(
  parameter int unsigned IW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid,
  input logic [IW-1:0] inflight
);

  a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_valid && (inflight == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: streaming, stall, redirects, PC wrap
// and mid-transfer reset against a behavioural in-order memory.
module tb_fetch_queue_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, imem_req_ready, imem_rsp_valid, redirect_valid, id_ready;
  logic [31:0]     imem_rsp_data;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid, id_valid, fetch_idle;
  logic [XLEN-1:0] imem_req_addr, id_pc;
  logic [31:0]     id_instr;

  logic            w_rsp_valid;
  logic [31:0]     w_rsp_data;
  logic            w_req_valid, w_id_valid, w_fetch_idle;
  logic [XLEN-1:0] w_req_addr, w_id_pc;
  logic [31:0]     w_id_instr;

  fetch_queue_unit #(.XLEN(XLEN), .RESET_PC(64'h0), .QDEPTH(4), .MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_idle(fetch_idle)
  );

  fetch_queue_unit #(.XLEN(XLEN), .RESET_PC(WRAP_PC), .QDEPTH(4), .MAX_OUTSTANDING(2)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .fetch_idle(w_fetch_idle)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  int first_acc = -1;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];
  logic [63:0] w_pop_pc[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then advance the memory model.
  task automatic tick();
    logic fire, rsp_taken, wfire;
    logic [63:0] addr, waddr;
    #1;
    fire = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    rsp_taken = imem_rsp_valid;
    wfire = w_req_valid;
    waddr = w_req_addr;
    if (fire) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (id_valid && id_ready) begin
      pop_pc.push_back(id_pc);
      pop_instr.push_back(id_instr);
      pop_cyc.push_back(cyc);
    end
    if (w_id_valid) w_pop_pc.push_back(w_id_pc);
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      w_rsp_valid    = 1'b0;
      w_rsp_data     = 32'h0;
    end else begin
      if (rsp_taken && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (fire) begin
        pend_addr.push_back(addr);
        pend_due.push_back(cyc - 1 + lat);
      end
      imem_rsp_valid = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
      imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr[0]) : 32'h0;
      w_rsp_valid    = wfire;
      w_rsp_data     = mem_word(waddr);
    end
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && pop_pc.size() < n; k++) tick();
    check_val(tag, pop_pc.size(), n);
  endtask

  task automatic clear_logs();
    pop_pc.delete();
    pop_instr.delete();
    pop_cyc.delete();
    w_pop_pc.delete();
    n_acc = 0;
    first_acc = -1;
  endtask

  initial begin
    int base;
    int found;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    repeat (2) tick();
    #1;
    check_val("rst_req_valid", imem_req_valid, 1'b0);
    check_val("rst_id_valid", id_valid, 1'b0);
    check_val("rst_id_instr", id_instr, 32'h0);
    check_val("rst_id_pc", id_pc, 64'h0);
    check_val("rst_fetch_idle", fetch_idle, 1'b1);
    check_val("rst_req_addr", imem_req_addr, 64'h0);
    check_val("rst_wrap_addr", w_req_addr, WRAP_PC);

    // Streaming from reset with 1-cycle memory.
    clear_logs();
    id_ready = 1'b1; imem_req_ready = 1'b1; rst = 1'b1;
    wait_pops("stream_count", 14, 40);
    for (int i = 0; i < 14; i++) begin
      check_val("stream_pc", pop_pc[i], 64'(4 * i));
      check_val("stream_instr", pop_instr[i], mem_word(64'(4 * i)));
      if (i > 0) check_val("stream_no_bubble", pop_cyc[i], pop_cyc[0] + i);
    end
    check_val("first_latency", pop_cyc[0] - first_acc, 2);
    check_val("wrap_pc0", w_pop_pc[0], 64'hFFFF_FFFF_FFFF_FFF8);
    check_val("wrap_pc1", w_pop_pc[1], 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("wrap_pc2", w_pop_pc[2], 64'h0);
    check_val("wrap_pc3", w_pop_pc[3], 64'h4);

    // Decode stall: queue fills to QDEPTH and requests stop.
    id_ready = 1'b0;
    repeat (10) tick();
    #1;
    check_val("stall_req_valid", imem_req_valid, 1'b0);
    check_val("stall_idle", fetch_idle, 1'b0);
    check_val("stall_id_valid", id_valid, 1'b1);
    check_val("stall_head_pc", id_pc, 64'(4 * pop_pc.size()));
    check_val("stall_held", n_acc - pop_pc.size(), 4);
    base = pop_pc.size();
    id_ready = 1'b1;
    wait_pops("unstall_count", base + 8, 40);
    for (int i = base; i < base + 8; i++) check_val("unstall_pc", pop_pc[i], 64'(4 * i));

    // Redirect with two latency-3 requests in flight.
    imem_req_ready = 1'b0;
    for (int k = 0; k < 20 && !fetch_idle; k++) tick();
    #1;
    check_val("drain_idle", fetch_idle, 1'b1);
    lat = 3; imem_req_ready = 1'b1;
    base = pop_pc.size();
    tick(); tick();
    #1;
    check_val("r1_no_rsp_yet", imem_rsp_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    #1;
    check_val("r1_id_valid", id_valid, 1'b0);
    check_val("r1_req_valid", imem_req_valid, 1'b0);
    check_val("r1_idle", fetch_idle, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_val("r1_addr", imem_req_addr, 64'h1000);
    wait_pops("r1_count", base + 2, 30);
    check_val("r1_pc0", pop_pc[base], 64'h1000);
    check_val("r1_instr0", pop_instr[base], mem_word(64'h1000));
    check_val("r1_pc1", pop_pc[base + 1], 64'h1004);

    // Redirect coinciding with a response and a decode handshake.
    lat = 2; id_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      #1;
      if (imem_rsp_valid && id_valid && !imem_req_valid) found = 1;
    end
    check_val("r2_found", found, 1);
    base = pop_pc.size();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000;
    #1;
    check_val("r2_id_valid", id_valid, 1'b0);
    check_val("r2_req_valid", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_val("r2_next_req_valid", imem_req_valid, 1'b1);
    check_val("r2_next_addr", imem_req_addr, 64'h2000);
    wait_pops("r2_count", base + 2, 30);
    check_val("r2_pc0", pop_pc[base], 64'h2000);
    check_val("r2_instr0", pop_instr[base], mem_word(64'h2000));
    check_val("r2_pc1", pop_pc[base + 1], 64'h2004);

    // Reset in the middle of traffic.
    lat = 3; id_ready = 1'b0;
    repeat (6) tick();
    #1;
    check_val("mid_busy", fetch_idle, 1'b0);
    rst = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check_val("mid_req_valid", imem_req_valid, 1'b0);
    check_val("mid_id_valid", id_valid, 1'b0);
    check_val("mid_id_instr", id_instr, 32'h0);
    check_val("mid_id_pc", id_pc, 64'h0);
    check_val("mid_idle", fetch_idle, 1'b1);
    check_val("mid_addr", imem_req_addr, 64'h0);
    repeat (2) tick();
    clear_logs();
    lat = 1; id_ready = 1'b1; rst = 1'b1;
    wait_pops("restart_count", 3, 20);
    for (int i = 0; i < 3; i++) check_val("restart_pc", pop_pc[i], 64'(4 * i));
    check_val("restart_wrap_pc0", w_pop_pc[0], WRAP_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
